// File: rtl/dm_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM states, requester ids.
package dm_arbiter_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {
    ST_RR     = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  typedef enum logic {
    ID_M0 = 1'b0,
    ID_M1 = 1'b1
  } id_e;

endpackage

// File: rtl/dm_arbiter_req_decode.sv
// Per-requester decode: byte address + size -> word address, byte enables, error.
module dm_req_decode
  import dm_arbiter_pkg::*;
#(
  parameter int          ADDR_W  = 12,
  parameter logic [31:0] DM_BASE = 32'h0000_0000
) (
  input  logic [31:0]       i_addr,
  input  logic [1:0]        i_size,
  output logic [ADDR_W-1:0] o_word_addr,
  output logic [3:0]        o_be,
  output logic              o_err
);

  logic w_oor;

  assign o_word_addr = i_addr[ADDR_W+1:2];
  assign w_oor       = (i_addr[31:ADDR_W+2] != DM_BASE[31:ADDR_W+2]);

  // Lane selection and alignment/range error; illegal size enables no lanes.
  always_comb begin
    o_be  = 4'b0000;
    o_err = w_oor;
    case (size_e'(i_size))
      SZ_WORD: begin
        o_be = 4'b1111;
        if (i_addr[1:0] != 2'b00) o_err = 1'b1;
      end
      SZ_HALF: begin
        o_be = i_addr[1] ? 4'b1100 : 4'b0011;
        if (i_addr[0]) o_err = 1'b1;
      end
      SZ_BYTE: o_be = 4'b0001 << i_addr[1:0];
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-port data memory, with M1 lock for atomic RMW.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] DM_BASE  = 32'h0000_0000,
  parameter int          LOCK_MAX = 16,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [1:0]        m0_size,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [1:0]        m1_size,
  input  logic [31:0]       m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wd,
  output logic              dm_memwr,
  output logic [3:0]        dm_be,
  input  logic [31:0]       dm_rd,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int LCNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  logic [NUM_REQ-1:0]             w_req, w_we, w_gnt, w_err, w_stall;
  logic [NUM_REQ-1:0][31:0]       w_addr, w_wdata;
  logic [NUM_REQ-1:0][1:0]        w_size;
  logic [NUM_REQ-1:0][ADDR_W-1:0] w_waddr;
  logic [NUM_REQ-1:0][3:0]        w_be;
  logic                           w_any, w_sel;
  logic [CNT_W:0]                 w_cnt_sum;

  state_e                         r_state, w_state_nxt;
  id_e                            r_rr_ptr, w_ptr_nxt;
  logic [LCNT_W-1:0]              r_lcnt, w_lcnt_nxt;
  logic [NUM_REQ-1:0]             r_rvalid, r_err;
  logic [NUM_REQ-1:0][31:0]       r_rdata;
  logic [CNT_W-1:0]               r_conflict;

  assign w_req   = {m1_req,   m0_req};
  assign w_we    = {m1_we,    m0_we};
  assign w_addr  = {m1_addr,  m0_addr};
  assign w_size  = {m1_size,  m0_size};
  assign w_wdata = {m1_wdata, m0_wdata};

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_dec
    dm_req_decode #(.ADDR_W(ADDR_W), .DM_BASE(DM_BASE)) u_dec (
      .i_addr      (w_addr[g]),
      .i_size      (w_size[g]),
      .o_word_addr (w_waddr[g]),
      .o_be        (w_be[g]),
      .o_err       (w_err[g])
    );
  end

  // Arbitration state, round-robin pointer and lock-hold counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_RR;
      r_rr_ptr <= ID_M0;
      r_lcnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_ptr_nxt;
      r_lcnt   <= w_lcnt_nxt;
    end
  end

  // Grant selection and next state; a locked M1 owns the port until unlock or timeout.
  always_comb begin
    w_gnt       = '0;
    w_state_nxt = r_state;
    w_ptr_nxt   = r_rr_ptr;
    w_lcnt_nxt  = r_lcnt;
    case (r_state)
      ST_RR: begin
        if (w_req[ID_M0] && (!w_req[ID_M1] || r_rr_ptr == ID_M0)) w_gnt[ID_M0] = 1'b1;
        else if (w_req[ID_M1])                                     w_gnt[ID_M1] = 1'b1;
        if (w_gnt[ID_M0]) w_ptr_nxt = ID_M1;
        if (w_gnt[ID_M1]) begin
          w_ptr_nxt = ID_M0;
          if (m1_lock) begin
            w_state_nxt = ST_LOCKED;
            w_lcnt_nxt  = '0;
          end
        end
      end
      ST_LOCKED: begin
        w_gnt[ID_M1] = w_req[ID_M1];
        w_lcnt_nxt   = r_lcnt + 1'b1;
        if (r_lcnt == LCNT_W'(LOCK_MAX - 1) || (w_gnt[ID_M1] && !m1_lock)) begin
          w_state_nxt = ST_RR;
          w_ptr_nxt   = ID_M0;
        end
      end
      default: w_state_nxt = ST_RR;
    endcase
  end

  // Memory port carries the granted side; idle port is all zero.
  assign w_any    = |w_gnt;
  assign w_sel    = w_gnt[ID_M1];
  assign dm_addr  = w_any ? w_waddr[w_sel] : '0;
  assign dm_be    = w_any ? w_be[w_sel]    : '0;
  assign dm_wd    = w_any ? w_wdata[w_sel] : '0;
  assign dm_memwr = w_any & w_we[w_sel] & ~w_err[w_sel];

  // Registered responses; rdata captures the pre-write word, zero on error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rvalid <= '0;
      r_err    <= '0;
      r_rdata  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_rvalid[i] <= w_gnt[i];
        r_err[i]    <= w_gnt[i] & w_err[i];
        r_rdata[i]  <= (w_gnt[i] && !w_err[i]) ? dm_rd : 32'h0;
      end
    end
  end

  assign w_stall   = w_req & ~w_gnt;
  assign w_cnt_sum = {1'b0, r_conflict} + {{CNT_W{1'b0}}, w_stall[0]} + {{CNT_W{1'b0}}, w_stall[1]};

  // Saturating count of requester-cycles spent waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              r_conflict <= '0;
    else if (w_cnt_sum[CNT_W]) r_conflict <= '1;
    else                     r_conflict <= w_cnt_sum[CNT_W-1:0];
  end

  assign m0_gnt       = w_gnt[ID_M0];
  assign m1_gnt       = w_gnt[ID_M1];
  assign m0_rvalid    = r_rvalid[ID_M0];
  assign m1_rvalid    = r_rvalid[ID_M1];
  assign m0_err       = r_err[ID_M0];
  assign m1_err       = r_err[ID_M1];
  assign m0_rdata     = r_rdata[ID_M0];
  assign m1_rdata     = r_rdata[ID_M1];
  assign conflict_cnt = r_conflict;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a behavioural model of the arbiter and the memory.
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  localparam int          ADDR_W   = 12;
  localparam logic [31:0] DM_BASE  = 32'h0000_0000;
  localparam int          LOCK_MAX = 16;
  localparam int          CNT_W    = 16;
  localparam int          DEPTH    = 1 << ADDR_W;

  logic clk = 1'b0, reset = 1'b0;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [1:0]  m0_size = 0, m1_size = 0;
  logic m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, dm_memwr;
  logic [31:0] m0_rdata, m1_rdata, dm_wd, dm_rd;
  logic [ADDR_W-1:0] dm_addr;
  logic [3:0] dm_be;
  logic [CNT_W-1:0] conflict_cnt;

  dm_arbiter #(.ADDR_W(ADDR_W), .DM_BASE(DM_BASE), .LOCK_MAX(LOCK_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_size(m0_size), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_size(m1_size), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_memwr(dm_memwr), .dm_be(dm_be), .dm_rd(dm_rd),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Data memory: combinational read, write on edge, right-aligned data placed by BE.
  logic [31:0] mem [0:DEPTH-1];
  bit mem_ok;
  assign dm_rd = mem[dm_addr];
  always @(posedge clk) begin
    if (!mem_ok) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
      mem_ok <= 1'b1;
    end else if (dm_memwr) begin
      case (dm_be)
        4'hF: mem[dm_addr]        <= dm_wd;
        4'h3: mem[dm_addr][15:0]  <= dm_wd[15:0];
        4'hC: mem[dm_addr][31:16] <= dm_wd[15:0];
        4'h1: mem[dm_addr][7:0]   <= dm_wd[7:0];
        4'h2: mem[dm_addr][15:8]  <= dm_wd[7:0];
        4'h4: mem[dm_addr][23:16] <= dm_wd[7:0];
        4'h8: mem[dm_addr][31:24] <= dm_wd[7:0];
        default: ;
      endcase
    end
  end

  // Literal expectations posted by the directed sequence for the current cycle.
  bit l_cv, l_g0, l_g1, l_wr, l_bev, l_rv, l_rv0, l_rv1, l_e0, l_e1, l_dv, l_kv;
  int l_a, l_k;
  logic [3:0] l_be;
  logic [31:0] l_d0;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void mdec(input logic [31:0] a, input logic [1:0] sz,
                               output bit err, output int wa, output logic [3:0] be);
    err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) ||
          ((a >> (ADDR_W + 2)) != (DM_BASE >> (ADDR_W + 2)));
    wa  = int'((a / 4) % DEPTH);
    if (sz == 2'd2)      be = 4'hF;
    else if (sz == 2'd1) be = ((a & 32'd2) != 0) ? 4'hC : 4'h3;
    else if (sz == 2'd0) be = 4'(1 << (a % 4));
    else                 be = 4'h0;
  endfunction

  // Model state
  bit m_locked; int m_lcnt; int m_last; int m_cnt;
  bit p_rv[2]; bit p_err[2]; logic [31:0] p_rd[2];
  logic [31:0] mmem [0:DEPTH-1];
  bit mmem_ok;

  // Compare process: mid-cycle check of every output against the model, then advance it.
  always @(negedge clk) begin : cmp
    logic [31:0] a[2], wd[2], mk, dmask;
    logic [1:0] sz[2];
    bit rq[2], we[2], e[2], g[2];
    int wa[2], s, sh;
    logic [3:0] be[2];
    if (!reset) begin
      chk("rst_rvalid0", 32'(m0_rvalid), 32'h0);
      chk("rst_rvalid1", 32'(m1_rvalid), 32'h0);
      chk("rst_conflict", 32'(conflict_cnt), 32'h0);
      m_locked = 0; m_lcnt = 0; m_last = 1; m_cnt = 0;
      for (int i = 0; i < 2; i++) begin p_rv[i] = 0; p_err[i] = 0; p_rd[i] = 0; end
      if (!mmem_ok) begin
        for (int i = 0; i < DEPTH; i++) mmem[i] = init_word(i);
        mmem_ok = 1;
      end
    end else begin
      chk("rvalid0", 32'(m0_rvalid), 32'(p_rv[0]));
      chk("rvalid1", 32'(m1_rvalid), 32'(p_rv[1]));
      if (p_rv[0]) begin chk("err0", 32'(m0_err), 32'(p_err[0])); chk("rdata0", m0_rdata, p_rd[0]); end
      if (p_rv[1]) begin chk("err1", 32'(m1_err), 32'(p_err[1])); chk("rdata1", m1_rdata, p_rd[1]); end
      chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
      if (l_cv) begin
        chk("lit_gnt0", 32'(m0_gnt), 32'(l_g0));
        chk("lit_gnt1", 32'(m1_gnt), 32'(l_g1));
        chk("lit_memwr", 32'(dm_memwr), 32'(l_wr));
        chk("lit_addr", 32'(dm_addr), 32'(l_a));
        if (l_bev) chk("lit_be", 32'(dm_be), 32'(l_be));
      end
      if (l_rv) begin
        chk("lit_rvalid0", 32'(m0_rvalid), 32'(l_rv0));
        chk("lit_rvalid1", 32'(m1_rvalid), 32'(l_rv1));
        if (l_rv0) chk("lit_err0", 32'(m0_err), 32'(l_e0));
        if (l_rv1) chk("lit_err1", 32'(m1_err), 32'(l_e1));
      end
      if (l_dv) chk("lit_rdata0", m0_rdata, l_d0);
      if (l_kv) chk("lit_conflict", 32'(conflict_cnt), 32'(l_k));

      rq[0] = m0_req; we[0] = m0_we; a[0] = m0_addr; sz[0] = m0_size; wd[0] = m0_wdata;
      rq[1] = m1_req; we[1] = m1_we; a[1] = m1_addr; sz[1] = m1_size; wd[1] = m1_wdata;
      for (int i = 0; i < 2; i++) mdec(a[i], sz[i], e[i], wa[i], be[i]);

      g[0] = 0; g[1] = 0;
      if (m_locked)            g[1] = rq[1];
      else if (rq[0] && rq[1]) g[1 - m_last] = 1;
      else if (rq[0])          g[0] = 1;
      else if (rq[1])          g[1] = 1;
      chk("gnt0", 32'(m0_gnt), 32'(g[0]));
      chk("gnt1", 32'(m1_gnt), 32'(g[1]));

      s = g[1] ? 1 : 0;
      if (g[0] || g[1]) begin
        chk("dm_addr", 32'(dm_addr), 32'(wa[s]));
        if (!e[s]) chk("dm_be", 32'(dm_be), 32'(be[s]));
        chk("dm_wd", dm_wd, wd[s]);
        chk("dm_memwr", 32'(dm_memwr), 32'(we[s] && !e[s]));
      end else begin
        chk("idle_memwr", 32'(dm_memwr), 32'h0);
        chk("idle_be", 32'(dm_be), 32'h0);
        chk("idle_addr", 32'(dm_addr), 32'h0);
        chk("idle_wd", dm_wd, 32'h0);
      end

      for (int i = 0; i < 2; i++) begin
        p_rv[i]  = g[i];
        p_err[i] = g[i] && e[i];
        p_rd[i]  = (g[i] && !e[i]) ? mmem[wa[i]] : 32'h0;
      end

      if ((g[0] || g[1]) && we[s] && !e[s]) begin
        if (sz[s] == 2'd2) mmem[wa[s]] = wd[s];
        else begin
          dmask = (sz[s] == 2'd1) ? 32'hFFFF : 32'hFF;
          sh    = (sz[s] == 2'd1) ? 8 * int'(a[s] & 32'd2) : 8 * int'(a[s] % 4);
          mk    = dmask << sh;
          mmem[wa[s]] = (mmem[wa[s]] & ~mk) | ((wd[s] & dmask) << sh);
        end
      end

      m_cnt = m_cnt + ((rq[0] && !g[0]) ? 1 : 0) + ((rq[1] && !g[1]) ? 1 : 0);
      if (m_cnt > (1 << CNT_W) - 1) m_cnt = (1 << CNT_W) - 1;

      if (m_locked) begin
        if (m_lcnt == LOCK_MAX - 1 || (g[1] && !m1_lock)) begin m_locked = 0; m_last = 1; end
        else m_lcnt++;
      end else begin
        if (g[0]) m_last = 0;
        if (g[1]) begin
          m_last = 1;
          if (m1_lock) begin m_locked = 1; m_lcnt = 0; end
        end
      end
    end
  end

  task automatic clr_lit();
    l_cv = 0; l_rv = 0; l_dv = 0; l_kv = 0;
  endtask
  task automatic expc(bit g0, bit g1, bit wr, int a, logic [3:0] be, bit bev);
    l_cv = 1; l_g0 = g0; l_g1 = g1; l_wr = wr; l_a = a; l_be = be; l_bev = bev;
  endtask
  task automatic expr(bit rv0, bit rv1, bit e0, bit e1);
    l_rv = 1; l_rv0 = rv0; l_rv1 = rv1; l_e0 = e0; l_e1 = e1;
  endtask
  task automatic expd(logic [31:0] d);
    l_dv = 1; l_d0 = d;
  endtask
  task automatic expk(int k);
    l_kv = 1; l_k = k;
  endtask
  task automatic set_m0(bit rq, bit w, logic [31:0] a, logic [1:0] sz, logic [31:0] d);
    m0_req = rq; m0_we = w; m0_addr = a; m0_size = sz; m0_wdata = d;
  endtask
  task automatic set_m1(bit rq, bit w, logic [31:0] a, logic [1:0] sz, logic [31:0] d, bit lk);
    m1_req = rq; m1_we = w; m1_addr = a; m1_size = sz; m1_wdata = d; m1_lock = lk;
  endtask
  task automatic idle();
    set_m0(0, 0, 0, 0, 0); set_m1(0, 0, 0, 0, 0, 0);
  endtask
  task automatic step();
    @(posedge clk); #1;
    clr_lit();
  endtask
  // mid=1 asserts reset in the second half of the current cycle, before its closing edge.
  task automatic do_reset(bit mid);
    if (mid) begin @(negedge clk); #1; end
    reset = 0; idle(); clr_lit();
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  bit g0s, g1s;

  initial begin
    clr_lit();
    repeat (3) @(posedge clk);
    #1 reset = 1;

    // Word store then load of the same address
    set_m0(1, 1, 32'h10, SZ_WORD, 32'hDEADBEEF); expc(1, 0, 1, 4, 4'hF, 1); step();
    set_m0(1, 0, 32'h10, SZ_WORD, 0); expc(1, 0, 0, 4, 4'hF, 1); expr(1, 0, 0, 0); step();
    idle(); expr(1, 0, 0, 0); expd(32'hDEADBEEF); step();

    // Contention from a fresh reset: M0, M1, M0, M1
    do_reset(0);
    for (int k = 0; k < 4; k++) begin
      set_m0(1, 0, 32'h20, SZ_WORD, 0); set_m1(1, 0, 32'h40, SZ_WORD, 0, 0);
      expc(k % 2 == 0, k % 2 == 1, 0, (k % 2 == 0) ? 8 : 16, 4'hF, 1);
      step();
    end
    idle(); expr(0, 1, 0, 0); expk(4); step();

    // Sub-word stores, then read the merged word
    set_m0(1, 1, 32'h13, SZ_BYTE, 32'h0000_00AB); expc(1, 0, 1, 4, 4'h8, 1); step();
    set_m0(1, 1, 32'h16, SZ_HALF, 32'h0000_1234); expc(1, 0, 1, 5, 4'hC, 1); expr(1, 0, 0, 0); step();
    set_m0(1, 0, 32'h10, SZ_WORD, 0); expc(1, 0, 0, 4, 4'hF, 1); step();
    idle(); expr(1, 0, 0, 0); expd(32'hABADBEEF); step();

    // Errors: misaligned half store, out-of-range word load
    set_m0(1, 1, 32'h11, SZ_HALF, 32'h5555); expc(1, 0, 0, 4, 4'h0, 0); step();
    set_m0(0, 0, 0, 0, 0); set_m1(1, 0, 32'h0001_0000, SZ_WORD, 0, 0);
    expc(0, 1, 0, 0, 4'h0, 0); expr(1, 0, 1, 0); expd(32'h0); step();
    idle(); expr(0, 1, 0, 1); step();

    // Lock: three locked M1 grants, M0 waits, unlock, then M0
    set_m1(1, 0, 32'h20, SZ_WORD, 0, 1); expc(0, 1, 0, 8, 4'hF, 1); step();
    for (int k = 0; k < 2; k++) begin
      set_m0(1, 0, 32'h24, SZ_WORD, 0); set_m1(1, 0, 32'h20, SZ_WORD, 0, 1);
      expc(0, 1, 0, 8, 4'hF, 1); step();
    end
    set_m1(1, 0, 32'h20, SZ_WORD, 0, 0); expc(0, 1, 0, 8, 4'hF, 1); step();
    expc(1, 0, 0, 9, 4'hF, 1); step();
    idle(); step();

    // Lock timeout: M1 keeps lock asserted; M0 gets in after 16 locked cycles
    for (int k = 0; k < 18; k++) begin
      set_m0(1, 0, 32'h24, SZ_WORD, 0); set_m1(1, 0, 32'h20, SZ_WORD, 0, 1);
      if (k < 17) expc(0, 1, 0, 8, 4'hF, 1); else expc(1, 0, 0, 9, 4'hF, 1);
      step();
    end
    idle(); step();

    // Reset while a load response is pending
    set_m0(1, 0, 32'h10, SZ_WORD, 0); expc(1, 0, 0, 4, 4'hF, 1);
    do_reset(1);
    expr(0, 0, 0, 0); expk(0); step();
    expr(0, 0, 0, 0); step();

    // Random traffic; a requester holds its request until granted
    g0s = 0; g1s = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 1000 == 999) begin do_reset(0); g0s = 0; g1s = 0; end
      clr_lit();
      if (!m0_req || g0s) begin
        m0_req   = ($urandom_range(0, 9) < 6);
        m0_we    = $urandom_range(0, 1) == 1;
        m0_size  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        m0_addr  = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 1) == 1) m0_addr = m0_addr & ~32'(m0_size == 2'd2 ? 3 : m0_size == 2'd1 ? 1 : 0);
        if ($urandom_range(0, 15) == 0) m0_addr = m0_addr | 32'h0001_0000;
        m0_wdata = $urandom;
      end
      if (!m1_req || g1s) begin
        m1_req   = ($urandom_range(0, 9) < 6);
        m1_we    = $urandom_range(0, 1) == 1;
        m1_lock  = ($urandom_range(0, 3) == 0);
        m1_size  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        m1_addr  = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 1) == 1) m1_addr = m1_addr & ~32'(m1_size == 2'd2 ? 3 : m1_size == 2'd1 ? 1 : 0);
        if ($urandom_range(0, 15) == 0) m1_addr = m1_addr | 32'hC000_0000;
        m1_wdata = $urandom;
      end
      @(negedge clk);
      g0s = m0_gnt; g1s = m1_gnt;
      @(posedge clk); #1;
    end
    idle(); clr_lit(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
